// File: rtl/mem_pkg.sv
// mem_pkg: shared width codes and datapath constants for the data-memory formatter
package mem_pkg;
  localparam int XLEN = 32;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  typedef enum logic {EXT_BYTE, EXT_HALF} ext_width_e;
endpackage

// File: rtl/mem_extend.sv
// mem_extend: truncate to byte or halfword lane 0, then sign- or zero-extend
module mem_extend
  import mem_pkg::*;
(
  input  logic [XLEN-1:0] data,
  input  ext_width_e      width,
  input  logic            sgn,
  output logic [XLEN-1:0] ext
);
  always_comb
    ext = width == EXT_HALF ? {{(XLEN-16){sgn & data[15]}}, data[15:0]}
                            : {{(XLEN-8){sgn & data[7]}}, data[7:0]};
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: funct3 width formatter shared by load and store paths, with sticky illegal-code flag
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] data_in,
  input  logic [2:0]      function3,
  output logic [XLEN-1:0] data_out,
  output logic            illegal,
  output logic            illegal_seen
);
  ext_width_e      width;
  logic            sgn;
  logic [XLEN-1:0] ext;
  mem_extend u_ext (
    .data  (data_in),
    .width (width),
    .sgn   (sgn),
    .ext   (ext)
  );
  // bit 2 of funct3 selects the unsigned variants; undefined codes pass the word through
  always_comb begin
    illegal  = function3 == 3'b011 || function3[2:1] == 2'b11;
    width    = (function3 == F3_H || function3 == F3_HU) ? EXT_HALF : EXT_BYTE;
    sgn      = !function3[2];
    data_out = (illegal || function3 == F3_W) ? data_in : ext;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) illegal_seen <= 1'b0;
    else if (illegal) illegal_seen <= 1'b1;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed checks of width formatting, store/load through a word memory, and the sticky flag
module tb_mem_access_unit;
  logic        clk;
  logic        rst;
  logic [31:0] data_in;
  logic [2:0]  function3;
  logic [31:0] data_out;
  logic        illegal;
  logic        illegal_seen;
  logic [31:0] mem [0:7];
  logic        we;
  logic [2:0]  addr;
  int checks;
  int errors;

  mem_access_unit #(.XLEN(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .data_in      (data_in),
    .function3    (function3),
    .data_out     (data_out),
    .illegal      (illegal),
    .illegal_seen (illegal_seen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // word-granular data memory: the formatted store data is captured at the clock edge
  always @(posedge clk) if (we) mem[addr] <= data_out;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic apply(input logic [31:0] d, input logic [2:0] f);
    data_in   = d;
    function3 = f;
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    we = 1'b0;
    addr = 3'd0;
    rst = 1'b0;
    data_in = 32'h0;
    function3 = 3'b010;
    #2;
    chk("reset_seen", {31'b0, illegal_seen}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    apply(32'h000000F0, 3'b000);
    chk("lb_data", data_out, 32'hFFFFFFF0);
    chk("lb_illegal", {31'b0, illegal}, 32'd0);
    apply(32'h000000F0, 3'b100);
    chk("lbu_data", data_out, 32'h000000F0);
    apply(32'h12348001, 3'b001);
    chk("lh_neg", data_out, 32'hFFFF8001);
    apply(32'h12348001, 3'b101);
    chk("lhu_neg", data_out, 32'h00008001);
    apply(32'h12347FFF, 3'b001);
    chk("lh_pos", data_out, 32'h00007FFF);
    apply(32'h12347FFF, 3'b101);
    chk("lhu_pos", data_out, 32'h00007FFF);
    apply(32'hFFFFFF9C, 3'b010);
    chk("lw_neg", data_out, 32'hFFFFFF9C);
    apply(32'h00000064, 3'b010);
    chk("lw_pos", data_out, 32'h00000064);
    apply(32'h12345681, 3'b000);
    chk("lb_upper_ignored", data_out, 32'hFFFFFF81);
    @(posedge clk); #1;
    chk("seen_after_legal", {31'b0, illegal_seen}, 32'd0);

    @(negedge clk);
    we = 1'b1; addr = 3'd5;
    apply(32'h00000080, 3'b000);
    @(negedge clk);
    we = 1'b0;
    apply(mem[5], 3'b010);
    chk("sb_then_lw", data_out, 32'hFFFFFF80);
    @(negedge clk);
    we = 1'b1; addr = 3'd5;
    apply(32'd200, 3'b010);
    @(negedge clk);
    we = 1'b0;
    apply(mem[5], 3'b010);
    chk("sw_then_lw", data_out, 32'd200);

    @(negedge clk);
    apply(32'hDEADBEEF, 3'b011);
    chk("ill011_data", data_out, 32'hDEADBEEF);
    chk("ill011_flag", {31'b0, illegal}, 32'd1);
    chk("seen_before_edge", {31'b0, illegal_seen}, 32'd0);
    apply(32'hCAFEF00D, 3'b110);
    chk("ill110_data", data_out, 32'hCAFEF00D);
    chk("ill110_flag", {31'b0, illegal}, 32'd1);
    apply(32'h01234567, 3'b111);
    chk("ill111_data", data_out, 32'h01234567);
    chk("ill111_flag", {31'b0, illegal}, 32'd1);
    @(posedge clk); #1;
    chk("seen_set", {31'b0, illegal_seen}, 32'd1);
    @(negedge clk);
    apply(32'hDEADBEEF, 3'b010);
    chk("legal_after_ill", {31'b0, illegal}, 32'd0);
    @(posedge clk); #1;
    chk("seen_sticky", {31'b0, illegal_seen}, 32'd1);

    @(negedge clk);
    apply(32'hDEADBEEF, 3'b011);
    rst = 1'b0;
    #1;
    chk("async_clear", {31'b0, illegal_seen}, 32'd0);
    chk("ill_during_rst", {31'b0, illegal}, 32'd1);
    @(posedge clk); #1;
    chk("held_in_rst", {31'b0, illegal_seen}, 32'd0);
    @(negedge clk);
    apply(32'h0, 3'b010);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("stays_clear", {31'b0, illegal_seen}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
